io_timer_irq: RTL and testbench

IO_TIMER_IRQ -- requirements
Module: io_timer_irq

---
 rtl/io_timer_irq_pkg.sv | 43 ++++
 rtl/io_timer_irq_sync_edge.sv | 38 +++
 rtl/io_timer_irq.sv | 160 ++++++++++++++++
 tb/tb_io_timer_irq.sv | 332 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/io_timer_irq_pkg.sv
// -----------------------------------------------------------------------------
// io_timer_irq_pkg
// Shared IO definitions for the timer / interrupt block: one-hot register
// addresses, STATUS bit positions and the address decode helper.
// No ports (package).
// -----------------------------------------------------------------------------
package io_timer_irq_pkg;

    // One-hot IO register addresses; several may be selected by one access.
    localparam logic [15:0] IO_TICKS_LO = 16'h0100;
    localparam logic [15:0] IO_TICKS_HI = 16'h0200;
    localparam logic [15:0] IO_RELOAD   = 16'h0400;
    localparam logic [15:0] IO_STATUS   = 16'h0800;
    localparam logic [15:0] IO_MASK     = 16'h1000;

    // Lowest address bit that carries a register select.
    localparam int IO_SEL_LSB = 8;

    // STATUS / MASK bit positions.
    localparam int STATUS_TIMER = 0;
    localparam int STATUS_EXT   = 1;
    localparam int STATUS_W     = 2;

    typedef struct packed {
        logic mask;
        logic status;
        logic reload;
        logic ticks_hi;
        logic ticks_lo;
    } io_sel_t;

    // Decode the select field (io_addr[12:8]) into per-register selects.
    function automatic io_sel_t io_decode(input logic [4:0] sel_bits);
        io_sel_t sel;
        sel.ticks_lo = sel_bits[0];
        sel.ticks_hi = sel_bits[1];
        sel.reload   = sel_bits[2];
        sel.status   = sel_bits[3];
        sel.mask     = sel_bits[4];
        return sel;
    endfunction

endpackage

// File: rtl/io_timer_irq_sync_edge.sv
// -----------------------------------------------------------------------------
// io_timer_irq_sync_edge (sync_edge)
// Multi-flop synchronizer for an asynchronous input followed by a rising-edge
// detector producing a one-cycle pulse.
// Ports:
//   clk    - clock
//   resetq - asynchronous active-low reset
//   din    - asynchronous input
//   pulse  - one-cycle pulse on a synchronized 0->1 transition of din
// -----------------------------------------------------------------------------
module io_timer_irq_sync_edge #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic resetq,
    input  logic din,
    output logic pulse
);

    logic [STAGES-1:0] sync_r;
    logic              last_r;

    // Synchronizer chain plus one history flop for edge detection.
    always_ff @(posedge clk or negedge resetq) begin
        if (!resetq) begin
            sync_r <= {STAGES{1'b0}};
            last_r <= 1'b0;
        end else begin
            sync_r <= {sync_r[STAGES-2:0], din};
            last_r <= sync_r[STAGES-1];
        end
    end

    // Both terms come straight from flops, so the pulse is glitch-free and
    // saves a cycle of interrupt latency compared with registering it again.
    assign pulse = sync_r[STAGES-1] & ~last_r;

endmodule

// File: rtl/io_timer_irq.sv
// -----------------------------------------------------------------------------
// io_timer_irq
// CPU IO-mapped timer and interrupt controller: 32-bit free-running cycle
// counter with coherent hi/lo readout, prescaled reloadable down-counter,
// synchronized external interrupt edge, STATUS (W1C) / MASK registers and a
// registered level interrupt request.
// Ports:
//   clk               - clock
//   resetq            - asynchronous active-low reset
//   io_rd, io_wr      - one-cycle CPU read / write strobes
//   io_addr           - one-hot register select (bits 12:8)
//   io_wdata          - write data
//   io_rdata          - registered read data (valid the cycle after io_rd)
//   ext_irq           - asynchronous external interrupt source
//   interrupt_request - registered level request to the CPU
// -----------------------------------------------------------------------------
module io_timer_irq
    import io_timer_irq_pkg::*;
#(
    parameter int PRESCALE    = 48,
    parameter int SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        resetq,
    input  logic        io_rd,
    input  logic        io_wr,
    input  logic [15:0] io_addr,
    input  logic [15:0] io_wdata,
    output logic [15:0] io_rdata,
    input  logic        ext_irq,
    output logic        interrupt_request
);

    localparam logic [15:0] PRESC_LOAD = 16'(PRESCALE - 1);

    logic [31:0]         cycle_cnt_r;
    logic [15:0]         shadow_r;
    logic [15:0]         reload_r;
    logic [STATUS_W-1:0] status_r;
    logic [STATUS_W-1:0] mask_r;
    logic [15:0]         presc_r;
    logic [15:0]         down_r;
    logic [15:0]         rdata_r;
    logic                irq_r;

    io_sel_t             sel_s;
    logic                reload_wr_s;
    logic                status_wr_s;
    logic                mask_wr_s;
    logic                timer_en_s;
    logic                tick_s;
    logic                expire_s;
    logic                ext_pulse_s;
    logic [STATUS_W-1:0] status_set_s;
    logic [STATUS_W-1:0] status_clr_s;
    logic [15:0]         rdata_s;
    logic                unused_s;

    assign sel_s       = io_decode(io_addr[IO_SEL_LSB+4:IO_SEL_LSB]);
    assign unused_s    = ^{io_addr[15:IO_SEL_LSB+5], io_addr[IO_SEL_LSB-1:0]};

    assign reload_wr_s = io_wr & sel_s.reload;
    assign status_wr_s = io_wr & sel_s.status;
    assign mask_wr_s   = io_wr & sel_s.mask;

    // A zero reload value parks the whole timer.
    assign timer_en_s  = (reload_r != 16'd0);
    assign tick_s      = timer_en_s & (presc_r == 16'd0);
    // A RELOAD write restarts the timer, so it suppresses an expiry that
    // would otherwise land in the same cycle.
    assign expire_s    = tick_s & (down_r == 16'd1) & ~reload_wr_s;

    io_timer_irq_sync_edge #(
        .STAGES (SYNC_STAGES)
    ) u_sync_edge (
        .clk    (clk),
        .resetq (resetq),
        .din    (ext_irq),
        .pulse  (ext_pulse_s)
    );

    assign status_set_s[STATUS_TIMER] = expire_s;
    assign status_set_s[STATUS_EXT]   = ext_pulse_s;
    assign status_clr_s = status_wr_s ? io_wdata[STATUS_W-1:0] : {STATUS_W{1'b0}};

    // Read mux: OR of every selected register; TICKS_HI returns the shadow
    // captured by an earlier TICKS_LO read.
    assign rdata_s = ({16{sel_s.ticks_lo}} & cycle_cnt_r[15:0])
                   | ({16{sel_s.ticks_hi}} & shadow_r)
                   | ({16{sel_s.reload}}   & reload_r)
                   | ({16{sel_s.status}}   & {14'd0, status_r})
                   | ({16{sel_s.mask}}     & {14'd0, mask_r});

    // Free-running cycle counter and the hi-half shadow for coherent reads.
    always_ff @(posedge clk or negedge resetq) begin
        if (!resetq) begin
            cycle_cnt_r <= 32'd0;
            shadow_r    <= 16'd0;
        end else begin
            cycle_cnt_r <= cycle_cnt_r + 32'd1;
            if (io_rd && sel_s.ticks_lo) begin
                shadow_r <= cycle_cnt_r[31:16];
            end
        end
    end

    // CPU-visible configuration registers and registered read data.
    always_ff @(posedge clk or negedge resetq) begin
        if (!resetq) begin
            reload_r <= 16'd0;
            mask_r   <= {STATUS_W{1'b0}};
            rdata_r  <= 16'd0;
        end else begin
            if (reload_wr_s) begin
                reload_r <= io_wdata;
            end
            if (mask_wr_s) begin
                mask_r <= io_wdata[STATUS_W-1:0];
            end
            if (io_rd) begin
                rdata_r <= rdata_s;
            end
        end
    end

    // Prescaler and tick down-counter; a RELOAD write restarts both.
    always_ff @(posedge clk or negedge resetq) begin
        if (!resetq) begin
            presc_r <= 16'd0;
            down_r  <= 16'd0;
        end else if (reload_wr_s) begin
            presc_r <= (io_wdata == 16'd0) ? 16'd0 : PRESC_LOAD;
            down_r  <= io_wdata;
        end else if (!timer_en_s) begin
            presc_r <= 16'd0;
            down_r  <= 16'd0;
        end else if (tick_s) begin
            presc_r <= PRESC_LOAD;
            // <= 1 rather than == 1 so a stray zero can never wrap to 0xFFFF.
            down_r  <= (down_r <= 16'd1) ? reload_r : (down_r - 16'd1);
        end else begin
            presc_r <= presc_r - 16'd1;
        end
    end

    // STATUS (set beats write-1-to-clear) and the registered request level.
    always_ff @(posedge clk or negedge resetq) begin
        if (!resetq) begin
            status_r <= {STATUS_W{1'b0}};
            irq_r    <= 1'b0;
        end else begin
            status_r <= (status_r & ~status_clr_s) | status_set_s;
            irq_r    <= |(status_r & mask_r);
        end
    end

    assign io_rdata          = rdata_r;
    assign interrupt_request = irq_r;

endmodule

// File: tb/tb_io_timer_irq.sv
// -----------------------------------------------------------------------------
// tb_io_timer_irq
// Self-checking bench for io_timer_irq. A behavioural model predicts every
// cycle's io_rdata and interrupt_request from register semantics: the cycle
// counter is "base + elapsed cycles", timer expiries are scheduled as
// write_cycle + k * RELOAD * PRESCALE, and external edges are looked up in a
// history of sampled ext_irq levels delayed by the synchronizer depth.
// -----------------------------------------------------------------------------
module tb_io_timer_irq;

    localparam int P = 4;
    localparam int S = 2;

    logic        clk;
    logic        resetq;
    logic        io_rd;
    logic        io_wr;
    logic [15:0] io_addr;
    logic [15:0] io_wdata;
    logic [15:0] io_rdata;
    logic        ext_irq;
    logic        interrupt_request;

    io_timer_irq #(
        .PRESCALE    (P),
        .SYNC_STAGES (S)
    ) dut (
        .clk               (clk),
        .resetq            (resetq),
        .io_rd             (io_rd),
        .io_wr             (io_wr),
        .io_addr           (io_addr),
        .io_wdata          (io_wdata),
        .io_rdata          (io_rdata),
        .ext_irq           (ext_irq),
        .interrupt_request (interrupt_request)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Model state
    int          cyc;
    logic [31:0] cnt_base;
    int          base_cyc;
    int          next_exp;
    logic [15:0] m_reload;
    logic [15:0] m_rdata;
    logic [15:0] m_shadow;
    logic [1:0]  m_status;
    logic [1:0]  m_mask;
    logic        m_irq;
    bit          ext_hist[$];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] cnt_at(input int c);
        return cnt_base + 32'(c - base_cyc);
    endfunction

    function automatic bit ext_at(input int c);
        if (c < 1 || c > ext_hist.size()) return 1'b0;
        return ext_hist[c-1];
    endfunction

    task automatic model_reset();
        cyc      = 0;
        cnt_base = 32'd0;
        base_cyc = 0;
        next_exp = -1;
        m_reload = 16'd0;
        m_rdata  = 16'd0;
        m_shadow = 16'd0;
        m_status = 2'd0;
        m_mask   = 2'd0;
        m_irq    = 1'b0;
        ext_hist.delete();
    endtask

    // Advance the model by one clock edge using the inputs presented for it.
    task automatic model_edge();
        logic [1:0]  st_old;
        logic [1:0]  mk_old;
        logic [1:0]  set_v;
        logic [1:0]  clr_v;
        logic [15:0] rl_old;
        logic [15:0] sh_old;
        logic [15:0] rd_v;
        logic [31:0] cnt_before;
        bit          expired;
        st_old     = m_status;
        mk_old     = m_mask;
        rl_old     = m_reload;
        sh_old     = m_shadow;
        cnt_before = cnt_at(cyc);
        cyc++;
        ext_hist.push_back(ext_irq);
        if (io_rd) begin
            rd_v = 16'h0000;
            if (io_addr[8]) begin
                rd_v     = rd_v | cnt_before[15:0];
                m_shadow = cnt_before[31:16];
            end
            if (io_addr[9])  rd_v = rd_v | sh_old;
            if (io_addr[10]) rd_v = rd_v | rl_old;
            if (io_addr[11]) rd_v = rd_v | {14'd0, st_old};
            if (io_addr[12]) rd_v = rd_v | {14'd0, mk_old};
            m_rdata = rd_v;
        end
        expired = (next_exp == cyc);
        if (io_wr && io_addr[10]) begin
            m_reload = io_wdata;
            expired  = 1'b0;
            next_exp = (io_wdata == 16'd0) ? -1 : cyc + int'(io_wdata) * P;
        end else if (expired) begin
            next_exp = cyc + int'(rl_old) * P;
        end
        set_v = {ext_at(cyc - S) && !ext_at(cyc - S - 1), expired};
        clr_v = (io_wr && io_addr[11]) ? io_wdata[1:0] : 2'b00;
        m_status = (st_old & ~clr_v) | set_v;
        if (io_wr && io_addr[12]) m_mask = io_wdata[1:0];
        m_irq = |(st_old & mk_old);
    endtask

    // One clock: present inputs at negedge, check both outputs #1 after posedge.
    task automatic step(input logic rd, input logic wr, input logic [15:0] addr,
                        input logic [15:0] wdata);
        io_rd    = rd;
        io_wr    = wr;
        io_addr  = addr;
        io_wdata = wdata;
        @(posedge clk);
        model_edge();
        #1;
        check_eq("rdata", {16'h0, io_rdata}, {16'h0, m_rdata});
        check_eq("irq", {31'h0, interrupt_request}, {31'h0, m_irq});
        @(negedge clk);
        io_rd = 1'b0;
        io_wr = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 16'h0000, 16'h0000);
    endtask

    task automatic rd_reg(input logic [15:0] addr);
        step(1'b1, 1'b0, addr, 16'h0000);
    endtask

    task automatic wr_reg(input logic [15:0] addr, input logic [15:0] data);
        step(1'b0, 1'b1, addr, data);
    endtask

    // Mid-cycle asynchronous reset; a MASK write held during reset must vanish.
    task automatic do_reset();
        #2;
        resetq = 1'b0;
        #1;
        check_eq("rst_rdata", {16'h0, io_rdata}, 32'h0);
        check_eq("rst_irq", {31'h0, interrupt_request}, 32'h0);
        model_reset();
        io_wr    = 1'b1;
        io_addr  = 16'h1000;
        io_wdata = 16'h0003;
        @(negedge clk);
        @(negedge clk);
        io_wr  = 1'b0;
        resetq = 1'b1;
    endtask

    task automatic force_cnt(input logic [31:0] val);
        force dut.cycle_cnt_r = val;
        #1;
        release dut.cycle_cnt_r;
        cnt_base = val;
        base_cyc = cyc;
    endtask

    logic [15:0] addr_tab [10] = '{16'h0100, 16'h0200, 16'h0400, 16'h0800, 16'h1000,
                                   16'h1800, 16'h0300, 16'h0C00, 16'h0001, 16'hFF00};

    initial begin
        int          first;
        int          rises[$];
        logic        prev;
        logic [15:0] lo;
        logic [15:0] hi;
        logic [15:0] a;
        logic [15:0] d;

        resetq   = 1'b1;
        io_rd    = 1'b0;
        io_wr    = 1'b0;
        io_addr  = 16'h0000;
        io_wdata = 16'h0000;
        ext_irq  = 1'b0;
        model_reset();
        @(negedge clk);
        do_reset();

        // Reset values of readable registers
        rd_reg(16'h1000);
        check_eq("reset_mask", {16'h0, io_rdata}, 32'h0);
        rd_reg(16'h0C00);
        check_eq("reset_status_reload", {16'h0, io_rdata}, 32'h0);

        // Multi-select read OR and empty select
        ext_irq = 1'b1;
        idle(4);
        wr_reg(16'h1000, 16'h0001);
        rd_reg(16'h1800);
        check_eq("rd_or_1800", {16'h0, io_rdata}, 32'h3);
        rd_reg(16'h0001);
        check_eq("rd_none", {16'h0, io_rdata}, 32'h0);
        wr_reg(16'h0800, 16'h0003);
        ext_irq = 1'b0;
        idle(3);

        // External edge: one STATUS[1] set, request 3 cycles after sampling
        do_reset();
        wr_reg(16'h1000, 16'h0002);
        ext_irq = 1'b1;
        first = -1;
        for (int i = 1; i <= 10; i++) begin
            idle(1);
            if (interrupt_request && first < 0) first = i;
        end
        check_eq("ext_latency", first, 4);
        rd_reg(16'h0800);
        check_eq("ext_status", {16'h0, io_rdata}, 32'h2);
        wr_reg(16'h0800, 16'h0002);
        idle(1);
        check_eq("irq_after_clear", {31'h0, interrupt_request}, 32'h0);
        rd_reg(16'h0800);
        check_eq("ext_single_set", {16'h0, io_rdata}, 32'h0);
        ext_irq = 1'b0;
        idle(3);

        // Timer: RELOAD=3, PRESCALE=4 -> request at 13, then every 12
        do_reset();
        wr_reg(16'h1000, 16'h0003);
        wr_reg(16'h0400, 16'h0003);
        prev = interrupt_request;
        for (int i = 1; i <= 30; i++) begin
            if (i == 14) wr_reg(16'h0800, 16'h0001);
            else         idle(1);
            if (interrupt_request && !prev) rises.push_back(i);
            prev = interrupt_request;
        end
        check_eq("timer_rises", rises.size(), 2);
        if (rises.size() >= 2) begin
            check_eq("timer_first", rises[0], 13);
            check_eq("timer_second", rises[1], 25);
        end

        // Set wins over a same-cycle W1C of STATUS[0]
        for (int k = 0; k < 100 && (next_exp - cyc) != 3; k++) idle(1);
        check_eq("t_align", next_exp - cyc, 3);
        wr_reg(16'h0800, 16'h0003);
        rd_reg(16'h0800);
        check_eq("status_cleared", {16'h0, io_rdata}, 32'h0);
        wr_reg(16'h0800, 16'h0001);
        rd_reg(16'h0800);
        check_eq("set_wins", {31'h0, io_rdata[0]}, 32'h1);

        // Coherent TICKS pair across the 0x0001_FFFF -> 0x0002_0000 carry
        force_cnt(32'h0001_FFFC);
        rd_reg(16'h0100);
        lo = io_rdata;
        idle(4);
        rd_reg(16'h0200);
        hi = io_rdata;
        check_eq("pair_a_lo", {16'h0, lo}, 32'hFFFC);
        check_eq("pair_a_hi", {16'h0, hi}, 32'h1);
        check_eq("pair_a_ok", {31'h0, (hi == 16'h1 && lo >= 16'hFFF0) ||
                                      (hi == 16'h2 && lo < 16'h0010)}, 32'h1);
        force_cnt(32'h0001_FFFE);
        idle(3);
        rd_reg(16'h0100);
        lo = io_rdata;
        idle(4);
        rd_reg(16'h0200);
        hi = io_rdata;
        check_eq("pair_b_lo", {16'h0, lo}, 32'h1);
        check_eq("pair_b_hi", {16'h0, hi}, 32'h2);
        force_cnt(32'hFFFF_FFFF);
        idle(1);
        rd_reg(16'h0100);
        lo = io_rdata;
        idle(4);
        rd_reg(16'h0200);
        hi = io_rdata;
        check_eq("wrap_lo", {16'h0, lo}, 32'h0);
        check_eq("wrap_hi", {16'h0, hi}, 32'h0);

        // Randomized traffic against the model
        do_reset();
        for (int n = 0; n < 600; n++) begin
            a = addr_tab[$urandom_range(0, 9)];
            if ($urandom_range(0, 9) == 0) a = 16'($urandom);
            d = a[10] ? 16'($urandom_range(0, 5)) : 16'($urandom);
            if ($urandom_range(0, 9) == 0) ext_irq = ~ext_irq;
            step($urandom_range(0, 99) < 40, $urandom_range(0, 99) < 30, a, d);
        end

        // Asynchronous reset with the request asserted mid-count
        do_reset();
        wr_reg(16'h1000, 16'h0001);
        wr_reg(16'h0400, 16'h0001);
        for (int k = 0; k < 20 && !interrupt_request; k++) idle(1);
        check_eq("pre_reset_irq", {31'h0, interrupt_request}, 32'h1);
        rd_reg(16'h0400);
        check_eq("pre_reset_rdata", {16'h0, io_rdata}, 32'h1);
        do_reset();
        rd_reg(16'h1000);
        check_eq("drop_in_reset", {16'h0, io_rdata}, 32'h0);
        idle(2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
